// File: rtl/joystick_scan_pkg.sv
// Shared types for the serial joystick chain scanner.
// Scan FSM encoding is exported so checkers can observe the current step.
package joystick_scan_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } scan_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/joystick_scan_debounce.sv
// Per-bit debounce over a window of committed scans, plus rising-edge and frame pulses.
// A bit of joy only follows the scan when the newest DEPTH scans all agree on it.
module joystick_scan_debounce #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit,
    input  logic [WIDTH-1:0] scan,
    output logic [WIDTH-1:0] joy,
    output logic [WIDTH-1:0] joyRise,
    output logic             frame
);

    localparam int HD = (DEPTH > 1) ? DEPTH - 1 : 1;

    logic [WIDTH-1:0] hist [HD];
    logic [WIDTH-1:0] agree;
    logic [WIDTH-1:0] joy_nx;

    always_comb begin
        agree = '1;
        for (int j = 0; j < DEPTH - 1; j++) begin
            agree = agree & ~(hist[j] ^ scan);
        end
        joy_nx = (agree & scan) | (~agree & joy);
    end

    // History starts as all-released so a press needs DEPTH real scans.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            joy     <= '0;
            joyRise <= '0;
            frame   <= 1'b0;
            for (int j = 0; j < HD; j++) begin
                hist[j] <= '0;
            end
        end else begin
            joyRise <= '0;
            frame   <= 1'b0;
            if (commit) begin
                joy     <= joy_nx;
                joyRise <= joy_nx & ~joy;
                frame   <= 1'b1;
                hist[0] <= scan;
                for (int j = 1; j < HD; j++) begin
                    hist[j] <= hist[j-1];
                end
            end
        end
    end

endmodule

// File: rtl/joystick_scan.sv
// Scans a daisy chain of parallel-load shift registers (PADS x BITS, 1 or 2 select phases)
// one FSM step per ce tick, then hands the assembled frame to the debouncer.
module joystick_scan
    import joystick_scan_pkg::*;
#(
    parameter int PADS     = 2,
    parameter int BITS     = 8,
    parameter int PHASES   = 1,
    parameter int DEBOUNCE = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ce,
    output logic                          joyCk,
    output logic                          joyLd,
    output logic                          joyS,
    input  logic                          joyD,
    output logic [PADS*PHASES*BITS-1:0]   joy,
    output logic [PADS*PHASES*BITS-1:0]   joyRise,
    output logic                          frame,
    output scan_state_e                   dbg_state
);

    localparam int W  = PADS * PHASES * BITS;
    localparam int BW = cnt_width(BITS);
    localparam int PW = cnt_width(PADS);
    localparam int IW = cnt_width(W);

    scan_state_e     state, state_nx;
    logic [BW-1:0]   btn;
    logic [PW-1:0]   pad;
    logic            half;
    logic            phase;
    logic [W-1:0]    scan;
    logic [IW-1:0]   sidx;
    logic            last_bit;
    logic            more_phases;
    logic            commit;

    always_comb begin
        sidx        = IW'((int'(pad) * PHASES + int'(phase)) * BITS + int'(btn));
        last_bit    = half && (btn == BW'(BITS - 1)) && (pad == PW'(PADS - 1));
        more_phases = int'(phase) < PHASES - 1;
        commit      = ce && (state == COMMIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SETTLE;
        end else if (ce) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            SETTLE: state_nx = LOAD;
            LOAD:   state_nx = SHIFT;
            SHIFT:  if (last_bit) state_nx = more_phases ? SETTLE : COMMIT;
            COMMIT: state_nx = SETTLE;
            default: state_nx = SETTLE;
        endcase
    end

    // joyS follows the phase register, which only moves on the way into SETTLE.
    always_comb begin
        joyLd     = 1'b1;
        joyCk     = 1'b0;
        joyS      = phase;
        dbg_state = state;
        case (state)
            LOAD:    joyLd = 1'b0;
            SHIFT:   joyCk = half;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn   <= '0;
            pad   <= '0;
            half  <= 1'b0;
            phase <= 1'b0;
            scan  <= '0;
        end else if (ce) begin
            case (state)
                LOAD: begin
                    btn  <= '0;
                    pad  <= '0;
                    half <= 1'b0;
                end
                SHIFT: begin
                    if (!half) begin
                        scan[sidx] <= ~joyD;
                        half       <= 1'b1;
                    end else begin
                        half <= 1'b0;
                        if (btn == BW'(BITS - 1)) begin
                            btn <= '0;
                            pad <= (pad == PW'(PADS - 1)) ? '0 : pad + PW'(1);
                        end else begin
                            btn <= btn + BW'(1);
                        end
                        if (last_bit && more_phases) phase <= 1'b1;
                    end
                end
                COMMIT: phase <= 1'b0;
                default: ;
            endcase
        end
    end

    joystick_scan_debounce #(
        .WIDTH (W),
        .DEPTH (DEBOUNCE)
    ) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .commit  (commit),
        .scan    (scan),
        .joy     (joy),
        .joyRise (joyRise),
        .frame   (frame)
    );

endmodule
